vscale_htif_tohost_monitor: RTL and testbench
=============================================

Name: vscale_htif_tohost_monitor

Overview:
Synthesizable HTIF host-side poller that replaces behavioural tohost polling in simulation and FPGA test harnesses. Drives the HTIF PCR request port of vscale_sim_top with periodic reads of CSR tohost and consumes the PCR responses. Decodes the result as pass, fail code or timeout, then clears tohost with a PCR write of 0. Sits directly between the test harness and the core's HTIF PCR interface.

Parameters:
PCR_WIDTH, 64, HTIF PCR data width; matches `HTIF_PCR_WIDTH.
TOHOST_ADDR, 12'h780, CSR address polled; matches `CSR_ADDR_TO_HOST.
POLL_INTERVAL, 16, idle cycles between polls; legal range 1..65535.
CYC_WIDTH, 64, width of the cycle counter and max_cycles.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; monitor runs while high
max_cycles  in  CYC_WIDTH  timeout limit; 0 disables timeout
htif_pcr_req_valid  out  1  PCR request valid
htif_pcr_req_ready  in  1  core accepts request
htif_pcr_req_rw  out  1  1=write, 0=read
htif_pcr_req_addr  out  12  always TOHOST_ADDR
htif_pcr_req_data  out  PCR_WIDTH  always 0; used only for the clear write
htif_pcr_resp_valid  in  1  response valid
htif_pcr_resp_ready  out  1  monitor accepts response
htif_pcr_resp_data  in  PCR_WIDTH  response data
done  out  1  sticky; test finished
pass  out  1  sticky; tohost==1 seen
timeout  out  1  sticky; cycle limit reached
fail_code  out  PCR_WIDTH-1  tohost>>1 when tohost>1
cycle_count  out  CYC_WIDTH  cycles with enable high since reset

Behaviour:
- Reset, asynchronous while reset_n low: state=WAIT, poll counter=0, cycle_count=0.
- All outputs at reset: req_valid=0, req_rw=0, resp_ready=0, done=0, pass=0, timeout=0, fail_code=0.
- cycle_count increments every cycle while enable=1 and done=0. It saturates at all-ones.
- FSM states: WAIT, RD_REQ, RD_RESP, CLR_REQ, CLR_RESP, DONE.
- WAIT: the poll counter counts enabled cycles. When it reaches POLL_INTERVAL-1, go to RD_REQ and clear the counter. If enable=0, the counter holds.
- RD_REQ: req_valid=1, rw=0. Stay until req_ready=1, then go to RD_RESP. valid must not drop and rw/addr must not change before the handshake.
- RD_RESP: resp_ready=1. On resp_valid:
  - data==0: go to WAIT.
  - data==1: set pass=1, go to CLR_REQ.
  - otherwise: capture fail_code=data[PCR_WIDTH-1:1], go to CLR_REQ.
- CLR_REQ: req_valid=1, rw=1, data=0. On req_ready go to CLR_RESP.
- CLR_RESP: resp_ready=1. On resp_valid go to DONE; the write response data is ignored.
- DONE: terminal. done=1, req_valid=0, resp_ready=0. Leaves only via reset.
- Timeout: when max_cycles!=0 and cycle_count==max_cycles while done=0, set timeout=1.
  - If no handshake is in flight (state WAIT or RD_REQ before accept), go to DONE immediately with req_valid dropped that cycle.
  - If in RD_RESP, CLR_REQ or CLR_RESP, finish that transaction first. A nonzero read result still sets pass/fail_code alongside timeout.
- A resp_valid and the timeout condition in the same cycle: the response is decoded first, and both flags may end up set.
- enable falling mid-transaction: the outstanding handshake completes, then the FSM parks in WAIT.
- done is asserted exactly one cycle after the CLR_RESP handshake or the timeout condition; all status outputs are registered.
- Only one outstanding PCR transaction exists at any time.
- Responses arriving outside RD_RESP/CLR_RESP are not accepted (resp_ready=0).

Decomposition:
- Shared package/header vscale_htif_monitor_pkg: FSM state encoding, default TOHOST_ADDR, and a result-decode constant for PASS=1.
- Reuse existing `HTIF_PCR_WIDTH and `CSR_ADDR_TO_HOST from the ctrl-constants and CSR-address headers.
- One natural sub-module: vscale_htif_poll_timer (poll-interval counter with enable and terminal pulse). The rest stays flat.

Test Plan:
1. POLL_INTERVAL=4, req_ready=1, resp returns 0 three times, then 1 → three reads spaced 4 cycles apart. Then one write with rw=1, data=0. done=1 and pass=1 one cycle after the write response; fail_code=0.
2. Read response 0x0000_0000_0000_0007 → fail_code=3, pass=0, clear write issued, done=1.
3. max_cycles=50, responses always 0 → timeout=1 and done=1 at cycle_count=50. req_valid is never high after done.
4. req_ready held low 10 cycles in RD_REQ → req_valid stays 1 with rw/addr stable. Exactly one read is accepted when ready rises.
5. Assert reset_n low while in RD_RESP → all outputs return to reset values asynchronously. After release, polling restarts from WAIT with cycle_count=0.
6. Response 1 arrives in the same cycle cycle_count==max_cycles → pass=1 and timeout=1. The clear write still completes before done=1.

Source files
------------

// File: rtl/vscale_htif_monitor_pkg.sv
// ----------------------------------------------------------------------------
// vscale_htif_monitor_pkg
//
// Shared definitions for the HTIF tohost monitor:
//   - default PCR data width and tohost CSR address (these mirror
//     `HTIF_PCR_WIDTH and `CSR_ADDR_TO_HOST of the core's headers)
//   - width of the poll-interval counter
//   - tohost result value that means "test passed"
//   - FSM state encoding
// ----------------------------------------------------------------------------
package vscale_htif_monitor_pkg;

    localparam int          HTIF_PCR_WIDTH_DEF   = 64;
    localparam logic [11:0] CSR_ADDR_TO_HOST_DEF = 12'h780;

    // POLL_INTERVAL is legal up to 65535, so POLL_INTERVAL-1 fits in 16 bits.
    localparam int          POLL_CNT_WIDTH       = 16;

    // tohost == 1 is a pass; any other nonzero value carries (code << 1) | 1.
    localparam int unsigned TOHOST_PASS          = 1;

    typedef enum logic [2:0] {
        S_WAIT     = 3'd0,
        S_RD_REQ   = 3'd1,
        S_RD_RESP  = 3'd2,
        S_CLR_REQ  = 3'd3,
        S_CLR_RESP = 3'd4,
        S_DONE     = 3'd5
    } mon_state_e;

endpackage

// File: rtl/vscale_htif_poll_timer.sv
// ----------------------------------------------------------------------------
// vscale_htif_poll_timer
//
// Counts cycles while 'run' is high and emits a one-cycle 'tick' on the
// cycle the count reaches POLL_INTERVAL-1; the count clears on that tick.
// While 'run' is low the count holds.
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   run      in   count this cycle
//   tick     out  terminal-count pulse (combinational from the count)
// ----------------------------------------------------------------------------
module vscale_htif_poll_timer
    import vscale_htif_monitor_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam logic [POLL_CNT_WIDTH-1:0] LAST = POLL_CNT_WIDTH'(POLL_INTERVAL - 1);

    logic [POLL_CNT_WIDTH-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (run) begin
            count <= count + POLL_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/vscale_htif_tohost_monitor.sv
// ----------------------------------------------------------------------------
// vscale_htif_tohost_monitor
//
// Host-side HTIF poller. Periodically reads CSR tohost over the PCR port,
// decodes the value (0 = keep polling, 1 = pass, other = fail code in the
// upper bits), clears tohost with a write of 0 and then parks in DONE.
// An optional cycle limit ends the run with 'timeout'.
//
// Handshake rule (both PCR channels): a transfer happens on a rising clk edge
// where valid and ready are both high. Once req_valid rises it stays high,
// with rw/addr/data unchanged, until accepted -- the only exception is a
// timeout hitting before acceptance, which drops req_valid in that same cycle.
// At most one PCR transaction is outstanding.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   enable                 monitor runs while high
//   max_cycles             timeout limit, 0 disables
//   htif_pcr_req_*         request channel to the core (valid/ready/rw/addr/data)
//   htif_pcr_resp_*        response channel from the core (valid/ready/data)
//   done, pass, timeout    sticky status
//   fail_code              tohost >> 1 when tohost > 1
//   cycle_count            enabled cycles since reset (stops at done/timeout)
// ----------------------------------------------------------------------------
module vscale_htif_tohost_monitor
    import vscale_htif_monitor_pkg::*;
#(
    parameter int          PCR_WIDTH     = HTIF_PCR_WIDTH_DEF,
    parameter logic [11:0] TOHOST_ADDR   = CSR_ADDR_TO_HOST_DEF,
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int          CYC_WIDTH     = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [CYC_WIDTH-1:0] max_cycles,
    output logic                 htif_pcr_req_valid,
    input  logic                 htif_pcr_req_ready,
    output logic                 htif_pcr_req_rw,
    output logic [11:0]          htif_pcr_req_addr,
    output logic [PCR_WIDTH-1:0] htif_pcr_req_data,
    input  logic                 htif_pcr_resp_valid,
    output logic                 htif_pcr_resp_ready,
    input  logic [PCR_WIDTH-1:0] htif_pcr_resp_data,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [PCR_WIDTH-2:0] fail_code,
    output logic [CYC_WIDTH-1:0] cycle_count
);

    mon_state_e           state;
    logic                 req_valid_q;
    logic                 req_rw_q;
    logic                 resp_ready_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 timeout_q;
    logic [PCR_WIDTH-2:0] fail_q;
    logic [CYC_WIDTH-1:0] cyc_q;

    logic timeout_hit;
    logic timeout_pend;
    logic poll_tick;

    assign timeout_hit  = (max_cycles != '0) && (cyc_q == max_cycles) && !done_q;
    assign timeout_pend = timeout_hit || timeout_q;

    vscale_htif_poll_timer #(
        .POLL_INTERVAL (POLL_INTERVAL)
    ) u_poll_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (enable && (state == S_WAIT)),
        .tick    (poll_tick)
    );

    // The counter stops while the timeout condition holds, so it reads back
    // as exactly max_cycles and the condition stays true until a transaction
    // already in flight has finished.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
        end else if (enable && !done_q && !timeout_hit && (cyc_q != '1)) begin
            cyc_q <= cyc_q + CYC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_WAIT;
            req_valid_q  <= 1'b0;
            req_rw_q     <= 1'b0;
            resp_ready_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_q       <= '0;
        end else begin
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
            case (state)
                S_WAIT: begin
                    if (timeout_hit) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else if (poll_tick) begin
                        state       <= S_RD_REQ;
                        req_valid_q <= 1'b1;
                        req_rw_q    <= 1'b0;
                    end
                end
                S_RD_REQ: begin
                    // req_valid is already masked this cycle on a timeout,
                    // so no read can be accepted alongside it.
                    if (timeout_hit) begin
                        state       <= S_DONE;
                        done_q      <= 1'b1;
                        req_valid_q <= 1'b0;
                    end else if (htif_pcr_req_ready) begin
                        state        <= S_RD_RESP;
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                    end
                end
                S_RD_RESP: begin
                    if (htif_pcr_resp_valid) begin
                        resp_ready_q <= 1'b0;
                        if (htif_pcr_resp_data == '0) begin
                            if (timeout_pend) begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else begin
                            if (htif_pcr_resp_data == PCR_WIDTH'(TOHOST_PASS)) begin
                                pass_q <= 1'b1;
                            end else begin
                                fail_q <= htif_pcr_resp_data[PCR_WIDTH-1:1];
                            end
                            state       <= S_CLR_REQ;
                            req_valid_q <= 1'b1;
                            req_rw_q    <= 1'b1;
                        end
                    end
                end
                S_CLR_REQ: begin
                    if (htif_pcr_req_ready) begin
                        state        <= S_CLR_RESP;
                        req_valid_q  <= 1'b0;
                        req_rw_q     <= 1'b0;
                        resp_ready_q <= 1'b1;
                    end
                end
                S_CLR_RESP: begin
                    // Write response data carries nothing of interest.
                    if (htif_pcr_resp_valid) begin
                        state        <= S_DONE;
                        resp_ready_q <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state        <= S_WAIT;
                    req_valid_q  <= 1'b0;
                    req_rw_q     <= 1'b0;
                    resp_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign htif_pcr_req_valid  = req_valid_q && !((state == S_RD_REQ) && timeout_hit);
    assign htif_pcr_req_rw     = req_rw_q;
    assign htif_pcr_req_addr   = TOHOST_ADDR;
    assign htif_pcr_req_data   = '0;
    assign htif_pcr_resp_ready = resp_ready_q;
    assign done                = done_q;
    assign pass                = pass_q;
    assign timeout             = timeout_q;
    assign fail_code           = fail_q;
    assign cycle_count         = cyc_q;

endmodule

// File: tb/tb_vscale_htif_tohost_monitor.sv
module tb_vscale_htif_tohost_monitor;

  localparam int POLL = 4;
  localparam logic [11:0] ADDR = 12'h780;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [63:0] max_cycles = '0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_rw;
  logic [11:0] req_addr;
  logic [63:0] req_data;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_data;
  logic        done, pass, timeout;
  logic [62:0] fail_code;
  logic [63:0] cycle_count;

  vscale_htif_tohost_monitor #(
    .POLL_INTERVAL (POLL)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .enable              (enable),
    .max_cycles          (max_cycles),
    .htif_pcr_req_valid  (req_valid),
    .htif_pcr_req_ready  (req_ready),
    .htif_pcr_req_rw     (req_rw),
    .htif_pcr_req_addr   (req_addr),
    .htif_pcr_req_data   (req_data),
    .htif_pcr_resp_valid (resp_valid),
    .htif_pcr_resp_ready (resp_ready),
    .htif_pcr_resp_data  (resp_data),
    .done                (done),
    .pass                (pass),
    .timeout             (timeout),
    .fail_code           (fail_code),
    .cycle_count         (cycle_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: expected request stream {rw, addr, data}
  logic [76:0] exp_q[$];
  logic [63:0] rd_script[$];
  logic        exp_pass, exp_wr;
  logic [63:0] exp_fail;

  // responder controls
  bit          rand_ready = 0, rand_delay = 0, resp_hold = 0, check_gap = 0;
  int          stall_budget = 0, stall_seen = 0;
  logic [63:0] resp_at_cc = '0;

  // responder state / logs
  int          cyc = 0;
  bit          pend = 0, pend_rw = 0;
  int          pend_delay = 0;
  logic [63:0] pend_data = '0;
  bit          prev_valid = 0, prev_hs = 0, prev_rw = 0, prev_done = 0;
  logic [11:0] prev_addr = '0;
  int          last_rd_resp_cyc = -1, wr_resp_cyc = -1, done_rise_cyc = -1;
  int          n_reads = 0, n_writes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the monitor keeps reading until tohost is nonzero;
  // a nonzero value is decoded and cleared with exactly one write of 0.
  task automatic model_predict();
    int n = 0;
    logic [63:0] v = '0;
    exp_q.delete();
    foreach (rd_script[i]) begin
      n++;
      v = rd_script[i];
      if (v != 0) break;
    end
    if (v == 0) begin
      exp_pass = 0; exp_fail = '0; exp_wr = 0;
      for (int i = 0; i < 32; i++) exp_q.push_back({1'b0, ADDR, 64'd0});
    end else begin
      exp_pass = (v == 1);
      exp_fail = (v > 1) ? (v >> 1) : 64'd0;
      exp_wr   = 1;
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, ADDR, 64'd0});
      exp_q.push_back({1'b1, ADDR, 64'd0});
    end
  endtask

  // PCR responder + protocol checks: drives at negedge, samples 1ns later
  initial begin : pcr_slave
    logic [76:0] exp_e;
    logic rh, sh;
    req_ready = 0; resp_valid = 0; resp_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        pend = 0; prev_valid = 0; prev_hs = 0; prev_done = 0;
        req_ready = 0; resp_valid = 0;
        continue;
      end
      if (stall_budget > 0 && req_valid) begin
        req_ready = 0; stall_budget--; stall_seen++;
      end else if (rand_ready) begin
        req_ready = ($urandom_range(0, 2) != 0);
      end else begin
        req_ready = 1;
      end
      resp_valid = 0;
      resp_data  = {$urandom, $urandom};
      if (pend && !resp_hold) begin
        if (pend_delay > 0) pend_delay--;
        else if (pend_rw || resp_at_cc == 0 || cycle_count == resp_at_cc) begin
          resp_valid = 1; resp_data = pend_data;
        end
      end
      #1;
      rh = req_valid && req_ready;
      sh = resp_valid && resp_ready;
      chk("resp_ready_iff_outstanding", resp_ready, pend);
      if (done) chk("req_valid_after_done", req_valid, 0);
      if (prev_valid && !prev_hs && !(max_cycles != 0 && cycle_count == max_cycles))
        chk("req_valid_held", req_valid, 1);
      if (prev_valid && !prev_hs && req_valid) begin
        chk("req_rw_stable", req_rw, prev_rw);
        chk("req_addr_stable", req_addr, prev_addr);
      end
      if (sh) begin
        if (!pend_rw) last_rd_resp_cyc = cyc;
        else wr_resp_cyc = cyc;
        pend = 0;
      end
      if (rh) begin
        chk("one_outstanding", pend, 0);
        chk("req_while_exp_q_empty", exp_q.size() == 0, 0);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          chk("req_rw", req_rw, exp_e[76]);
          chk("req_addr", req_addr, exp_e[75:64]);
          chk("req_data", req_data, exp_e[63:0]);
        end
        if (!req_rw && check_gap && last_rd_resp_cyc >= 0)
          chk("poll_gap", cyc - last_rd_resp_cyc, POLL + 1);
        pend = 1;
        pend_rw = req_rw;
        pend_delay = rand_delay ? int'($urandom_range(0, 3)) : 0;
        if (req_rw) begin
          n_writes++;
          pend_data = {$urandom, $urandom};
        end else begin
          n_reads++;
          pend_data = (rd_script.size() != 0) ? rd_script.pop_front() : 64'd0;
        end
      end
      if (done && !prev_done) done_rise_cyc = cyc;
      prev_done  = done;
      prev_valid = req_valid;
      prev_hs    = rh;
      prev_rw    = req_rw;
      prev_addr  = req_addr;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: observed time limit expired, required run completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_req_valid"}, req_valid, 0);
    chk({nm, "_req_rw"}, req_rw, 0);
    chk({nm, "_resp_ready"}, resp_ready, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass, 0);
    chk({nm, "_timeout"}, timeout, 0);
    chk({nm, "_fail_code"}, fail_code, 0);
    chk({nm, "_cycle_count"}, cycle_count, 0);
  endtask

  task automatic do_reset(input logic [63:0] mc);
    reset_n = 0;
    enable  = 0;
    repeat (3) @(negedge clk);
    max_cycles = mc;
    rand_ready = 0; rand_delay = 0; resp_hold = 0; check_gap = 0;
    stall_budget = 0; stall_seen = 0; resp_at_cc = '0;
    rd_script.delete(); exp_q.delete();
    last_rd_resp_cyc = -1; wr_resp_cyc = -1; done_rise_cyc = -1;
    n_reads = 0; n_writes = 0;
    #2 reset_n = 1;
    @(negedge clk);
    #2;
    check_reset_outputs("reset");
  endtask

  task automatic finish_check(input string nm, input logic exp_to);
    int i = 0;
    while (!done && i < 3000) begin
      @(negedge clk);
      i++;
    end
    #2;
    chk({nm, "_done_in_budget"}, done, 1);
    repeat (5) @(negedge clk);
    #2;
    chk({nm, "_pass"}, pass, exp_pass);
    chk({nm, "_fail_code"}, fail_code, exp_fail);
    chk({nm, "_timeout"}, timeout, exp_to);
    chk({nm, "_writes"}, n_writes, exp_wr);
    if (exp_wr) begin
      chk({nm, "_exp_q_drained"}, exp_q.size(), 0);
      chk({nm, "_done_latency"}, done_rise_cyc - wr_resp_cyc, 1);
    end
  endtask

  initial begin : main
    logic [63:0] v;
    int k;

    // 1: basic pass, no polling while disabled, poll spacing
    do_reset(0);
    repeat (20) @(negedge clk);
    #2;
    chk("idle_cycle_count", cycle_count, 0);
    chk("idle_no_reads", n_reads, 0);
    check_gap = 1;
    rd_script = '{64'd0, 64'd0, 64'd0, 64'd1};
    model_predict();
    enable = 1;
    finish_check("basic_pass", 0);
    chk("basic_pass_reads", n_reads, 4);

    // 2: fail code 7 -> 3, random handshakes
    do_reset(0);
    rand_ready = 1; rand_delay = 1;
    rd_script = '{64'd7};
    model_predict();
    enable = 1;
    finish_check("fail7", 0);

    // 3: timeout at 50 with tohost stuck at 0
    do_reset(50);
    model_predict();
    enable = 1;
    finish_check("timeout50", 1);
    chk("timeout50_cycle_count", cycle_count, 50);

    // 4: request stalled for 10 cycles
    do_reset(0);
    stall_budget = 10;
    rd_script = '{64'd1};
    model_predict();
    enable = 1;
    finish_check("stall", 0);
    chk("stall_cycles", stall_seen, 10);
    chk("stall_reads", n_reads, 1);

    // 5: asynchronous reset while waiting for a read response
    do_reset(0);
    resp_hold = 1;
    rd_script = '{64'd0};
    model_predict();
    enable = 1;
    for (int i = 0; i < 100 && !resp_ready; i++) @(negedge clk);
    #2;
    chk("rst_reached_rd_resp", resp_ready, 1);
    chk("rst_count_running", cycle_count != 0, 1);
    reset_n = 0;
    #1;
    check_reset_outputs("async_reset");
    do_reset(0);
    rd_script = '{64'd1};
    model_predict();
    enable = 1;
    finish_check("after_reset", 0);

    // 6: pass response coincides with the timeout cycle
    do_reset(20);
    resp_at_cc = 20;
    rd_script = '{64'd1};
    model_predict();
    enable = 1;
    finish_check("coincide", 1);
    chk("coincide_cycle_count", cycle_count, 20);

    // 7: random scripts with random handshake timing
    for (int r = 0; r < 4; r++) begin
      do_reset(0);
      rand_ready = 1; rand_delay = 1;
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) rd_script.push_back(64'd0);
      v = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) v = 64'd1;
      if (v == 0) v = 64'd5;
      rd_script.push_back(v);
      model_predict();
      enable = 1;
      finish_check($sformatf("rand%0d", r), 0);
      chk($sformatf("rand%0d_reads", r), n_reads, k + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
